// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the hazard/stall controller: register index, the slice of
// the pipeline control word the controller looks at, and the FSM state codes.
package hazard_stall_ctrl_pkg;

  typedef logic [4:0] rv32i_reg;

  typedef struct packed {
    logic read_mem;
    logic write_mem;
    logic write_reg;
  } rv32i_control_word;

  typedef logic [1:0] hzd_state_t;

  localparam hzd_state_t HZD_RUN        = 2'd0;
  localparam hzd_state_t HZD_IMISS      = 2'd1;
  localparam hzd_state_t HZD_DMISS      = 2'd2;
  localparam hzd_state_t HZD_REDIR_WAIT = 2'd3;

endpackage

// File: rtl/hazard_stall_ctrl_perf.sv
// Three saturating performance counters for the hazard controller: stall
// cycles, ID/EX bubbles and IF/ID flushes. Cleared by the synchronous
// active-low reset.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stallCnt_q, bubbleCnt_q, flushCnt_q;

  // Count each event once per cycle, holding at all-ones instead of wrapping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      if (stall_i && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + 1'b1;
      if (bubble_i && (bubbleCnt_q != '1))
        bubbleCnt_q <= bubbleCnt_q + 1'b1;
      if (flush_i && (flushCnt_q != '1))
        flushCnt_q <= flushCnt_q + 1'b1;
    end
  end

  assign stall_cnt_o  = stallCnt_q;
  assign bubble_cnt_o = bubbleCnt_q;
  assign flush_cnt_o  = flushCnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core. Produces the
// per-stage load enables and NOP-insert flushes for load-use bubbles, cache
// miss freezes and taken-branch redirects. Define HAZARD_PERF_CNT_EN to build
// the stall/bubble/flush performance counters; otherwise they read as zero.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_reg          rs1_id_IfId,
  input  rv32i_reg          rs2_id_IfId,
  input  logic              rs1_used_IfId,
  input  logic              rs2_used_IfId,
  input  rv32i_reg          rd_id_IdEx,
  input  rv32i_control_word control_word_IdEx,
  input  rv32i_control_word control_word_ExMem,
  input  logic              br_taken_Ex,
  input  logic              icache_resp,
  input  logic              dcache_resp,
  output logic              load_pc,
  output logic              load_IfId,
  output logic              load_IdEx,
  output logic              load_ExMem,
  output logic              load_MemWb,
  output logic              flush_IfId,
  output logic              flush_IdEx,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hzd_state_t state_q, state_d;
  logic       redirPend_q, redirPend_d;

  logic dmissNow;
  logic imissNow;
  logic loadUse;
  logic staleFetch;
  logic unusedCwBits;

  assign dmissNow = (control_word_ExMem.read_mem | control_word_ExMem.write_mem) & ~dcache_resp;
  assign imissNow = ~icache_resp;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign loadUse = control_word_IdEx.read_mem & control_word_IdEx.write_reg &
                   (rd_id_IdEx != 5'd0) &
                   ((rs1_used_IfId & (rs1_id_IfId == rd_id_IdEx)) |
                    (rs2_used_IfId & (rs2_id_IfId == rd_id_IdEx)));

  // A redirect is pending in REDIR_WAIT, and also while a D-miss froze it
  assign staleFetch = (state_q == HZD_REDIR_WAIT) | ((state_q == HZD_DMISS) & redirPend_q);

  assign unusedCwBits = ^{control_word_IdEx.write_mem, control_word_ExMem.write_reg};

  // Per-cycle enables/flushes, resolved in priority dmiss > imiss > redirect > load-use
  always_comb begin
    load_pc    = 1'b1;
    load_IfId  = 1'b1;
    load_IdEx  = 1'b1;
    load_ExMem = 1'b1;
    load_MemWb = 1'b1;
    flush_IfId = 1'b0;
    flush_IdEx = 1'b0;
    if (!rst || dmissNow) begin
      load_pc    = 1'b0;
      load_IfId  = 1'b0;
      load_IdEx  = 1'b0;
      load_ExMem = 1'b0;
      load_MemWb = 1'b0;
    end else if (staleFetch) begin
      // PC already holds the branch target; the returning fetch is wrong-path
      load_pc    = 1'b0;
      load_IfId  = icache_resp;
      flush_IfId = icache_resp;
      flush_IdEx = 1'b1;
    end else if (imissNow) begin
      load_pc    = br_taken_Ex;
      load_IfId  = 1'b0;
      flush_IdEx = 1'b1;
    end else if (br_taken_Ex) begin
      flush_IfId = 1'b1;
      flush_IdEx = 1'b1;
    end else if (loadUse) begin
      load_pc    = 1'b0;
      load_IfId  = 1'b0;
      flush_IdEx = 1'b1;
    end
  end

  // Track which miss/redirect condition the pipeline is sitting in
  always_comb begin
    state_d     = state_q;
    redirPend_d = redirPend_q;
    if (!rst) begin
      state_d     = HZD_RUN;
      redirPend_d = 1'b0;
    end else if (dmissNow) begin
      state_d = HZD_DMISS;
    end else if (staleFetch) begin
      if (icache_resp) begin
        state_d     = HZD_RUN;
        redirPend_d = 1'b0;
      end else begin
        state_d = HZD_REDIR_WAIT;
      end
    end else if (imissNow) begin
      if (br_taken_Ex) begin
        state_d     = HZD_REDIR_WAIT;
        redirPend_d = 1'b1;
      end else begin
        state_d = HZD_IMISS;
      end
    end else begin
      state_d = HZD_RUN;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HZD_RUN;
      redirPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      redirPend_q <= redirPend_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stallEvt;
  assign stallEvt = rst & ~(load_pc & load_IfId & load_IdEx & load_ExMem & load_MemWb);

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i        (clk),
    .rst_ni       (rst),
    .stall_i      (stallEvt),
    .bubble_i     (flush_IdEx),
    .flush_i      (flush_IfId),
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt),
    .flush_cnt_o  (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a rule-level model.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // Output vector order: {load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx}
  localparam logic [6:0] V_ALL    = 7'b1111100;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_BUBBLE = 7'b0011101;
  localparam logic [6:0] V_BRANCH = 7'b1111111;
  localparam logic [6:0] V_REDIM  = 7'b1011101;
  localparam logic [6:0] V_STALE  = 7'b0111111;

  logic clk = 1'b0;
  logic rst;
  rv32i_reg rs1_id_IfId, rs2_id_IfId, rd_id_IdEx;
  logic rs1_used_IfId, rs2_used_IfId;
  rv32i_control_word control_word_IdEx, control_word_ExMem;
  logic br_taken_Ex, icache_resp, dcache_resp;
  logic load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int total = 0;
  int bad = 0;
  logic checkEn = 1'b0;

  // Model state: a redirect whose wrong-path fetch is still outstanding, plus event tallies
  logic mPend = 1'b0;
  logic [CNT_W-1:0] mStall = '0, mBubble = '0, mFlush = '0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .rs1_id_IfId        (rs1_id_IfId),
    .rs2_id_IfId        (rs2_id_IfId),
    .rs1_used_IfId      (rs1_used_IfId),
    .rs2_used_IfId      (rs2_used_IfId),
    .rd_id_IdEx         (rd_id_IdEx),
    .control_word_IdEx  (control_word_IdEx),
    .control_word_ExMem (control_word_ExMem),
    .br_taken_Ex        (br_taken_Ex),
    .icache_resp        (icache_resp),
    .dcache_resp        (dcache_resp),
    .load_pc            (load_pc),
    .load_IfId          (load_IfId),
    .load_IdEx          (load_IdEx),
    .load_ExMem         (load_ExMem),
    .load_MemWb         (load_MemWb),
    .flush_IfId         (flush_IfId),
    .flush_IdEx         (flush_IdEx),
    .stall_cnt          (stall_cnt),
    .bubble_cnt         (bubble_cnt),
    .flush_cnt          (flush_cnt)
  );

  wire [6:0] outs = {load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx};

  // What the controller must request this cycle, straight from the hazard rules
  function automatic logic [6:0] expectedOut();
    logic dataMiss, dependent;
    dataMiss = (control_word_ExMem.read_mem || control_word_ExMem.write_mem) && !dcache_resp;
    dependent = control_word_IdEx.read_mem && control_word_IdEx.write_reg && rd_id_IdEx != 0 &&
                ((rs1_used_IfId && rs1_id_IfId == rd_id_IdEx) || (rs2_used_IfId && rs2_id_IfId == rd_id_IdEx));
    if (!rst) return V_FREEZE;
    if (dataMiss) return V_FREEZE;
    if (mPend) return icache_resp ? V_STALE : V_BUBBLE;
    if (!icache_resp) return br_taken_Ex ? V_REDIM : V_BUBBLE;
    if (br_taken_Ex) return V_BRANCH;
    if (dependent) return V_BUBBLE;
    return V_ALL;
  endfunction

  // Advance the model at each clock edge using the inputs seen during the cycle
  always @(posedge clk) begin
    logic [6:0] e;
    logic dataMiss;
    e = expectedOut();
    dataMiss = (control_word_ExMem.read_mem || control_word_ExMem.write_mem) && !dcache_resp;
    if (!rst) begin
      mPend = 1'b0;
      mStall = '0;
      mBubble = '0;
      mFlush = '0;
    end else begin
      if (e[6:2] != 5'b11111 && mStall != '1) mStall = mStall + 1;
      if (e[0] && mBubble != '1) mBubble = mBubble + 1;
      if (e[1] && mFlush != '1) mFlush = mFlush + 1;
      if (!dataMiss) begin
        if (mPend) begin
          if (icache_resp) mPend = 1'b0;
        end else if (!icache_resp && br_taken_Ex) begin
          mPend = 1'b1;
        end
      end
    end
  end

  // Every-cycle compare of DUT outputs and counters against the model
  always @(negedge clk) begin
    if (checkEn) begin
      logic [6:0] e;
      logic [CNT_W-1:0] es, eb, ef;
      e = expectedOut();
`ifdef HAZARD_PERF_CNT_EN
      es = mStall; eb = mBubble; ef = mFlush;
`else
      es = '0; eb = '0; ef = '0;
`endif
      total++;
      if (outs !== e) begin
        bad++;
        $display("[TB] FAIL model_out t=%0t: got %b expected %b", $time, outs, e);
      end
      total++;
      if (stall_cnt !== es || bubble_cnt !== eb || flush_cnt !== ef) begin
        bad++;
        $display("[TB] FAIL model_cnt t=%0t: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 $time, stall_cnt, bubble_cnt, flush_cnt, es, eb, ef);
      end
    end
  end

  // Consume n cycles with the current inputs
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Check the output vector mid-cycle against a literal, then move to the next cycle
  task automatic checkOutput(input string name, input logic [6:0] exp);
    @(negedge clk);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, outs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Check one counter value against a literal
  task automatic checkCount(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Any stuck simulation ends here
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    logic [CNT_W-1:0] e5, e1, e0;
    rst = 1'b0;
    rs1_id_IfId = 0; rs2_id_IfId = 0; rd_id_IdEx = 0;
    rs1_used_IfId = 0; rs2_used_IfId = 0;
    control_word_IdEx = '0; control_word_ExMem = '0;
    br_taken_Ex = 0; icache_resp = 1; dcache_resp = 0;
    checkEn = 1'b1;

    checkOutput("reset_outputs", V_FREEZE);
    checkCount("reset_stall_cnt", stall_cnt, '0);
    checkOutput("reset_outputs2", V_FREEZE);
    rst = 1'b1;
    checkOutput("idle_run", V_ALL);

    // Load-use on rs1: one bubble, then the EX slot holds the bubble
    control_word_IdEx = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b1};
    rd_id_IdEx = 5'd3; rs1_id_IfId = 5'd3; rs1_used_IfId = 1'b1;
    checkOutput("loaduse_rs1", V_BUBBLE);
    control_word_IdEx = '0;
    checkOutput("loaduse_release", V_ALL);

    // D-miss for four cycles, then the response cycle runs
    control_word_ExMem = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b1};
    for (int i = 0; i < 4; i++) checkOutput("dmiss_freeze", V_FREEZE);
    dcache_resp = 1'b1;
    checkOutput("dmiss_resp", V_ALL);
    control_word_ExMem = '0; dcache_resp = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    e5 = 5; e1 = 1; e0 = 0;
`else
    e5 = 0; e1 = 0; e0 = 0;
`endif
    checkCount("perf_stall_cnt", stall_cnt, e5);
    checkCount("perf_bubble_cnt", bubble_cnt, e1);
    checkCount("perf_flush_cnt", flush_cnt, e0);

    // x0 never stalls
    control_word_IdEx = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b1};
    rd_id_IdEx = 5'd0; rs1_id_IfId = 5'd0; rs1_used_IfId = 1'b1;
    checkOutput("x0_no_stall", V_ALL);

    // rs2 dependency stalls; unused rs1 match does not
    rd_id_IdEx = 5'd5; rs1_id_IfId = 5'd5; rs1_used_IfId = 1'b0;
    rs2_id_IfId = 5'd9; rs2_used_IfId = 1'b1;
    checkOutput("rs1_unused_match", V_ALL);
    rs2_id_IfId = 5'd5;
    checkOutput("loaduse_rs2", V_BUBBLE);
    control_word_IdEx.write_reg = 1'b0;
    checkOutput("no_write_reg", V_ALL);
    control_word_IdEx = '0; rs2_used_IfId = 1'b0;

    // Taken branch with fetch idle
    br_taken_Ex = 1'b1;
    checkOutput("branch_redirect", V_BRANCH);
    br_taken_Ex = 1'b0;

    // Plain I-miss
    icache_resp = 1'b0;
    checkOutput("imiss", V_BUBBLE);
    checkOutput("imiss_hold", V_BUBBLE);
    icache_resp = 1'b1;
    checkOutput("imiss_done", V_ALL);

    // Branch during I-miss, stale fetch returns three cycles later
    icache_resp = 1'b0; br_taken_Ex = 1'b1;
    checkOutput("redir_imiss", V_REDIM);
    br_taken_Ex = 1'b0;
    checkOutput("redir_wait1", V_BUBBLE);
    checkOutput("redir_wait2", V_BUBBLE);
    icache_resp = 1'b1;
    checkOutput("stale_flush", V_STALE);
    checkOutput("after_stale", V_ALL);

    // Simultaneous dmiss + redirect + load-use
    control_word_ExMem = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b0};
    control_word_IdEx = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b1};
    rd_id_IdEx = 5'd3; rs1_id_IfId = 5'd3; rs1_used_IfId = 1'b1;
    br_taken_Ex = 1'b1;
    checkOutput("combo_freeze", V_FREEZE);
    checkOutput("combo_freeze2", V_FREEZE);
    dcache_resp = 1'b1;
    checkOutput("combo_redirect", V_BRANCH);
    br_taken_Ex = 1'b0; control_word_IdEx = '0; control_word_ExMem = '0; dcache_resp = 1'b0;
    checkOutput("combo_after", V_ALL);

    // Reset asserted in the middle of a D-miss
    control_word_ExMem = '{read_mem: 1'b0, write_mem: 1'b1, write_reg: 1'b0};
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_mid_dmiss", V_FREEZE);
    checkCount("rst_stall_cnt", stall_cnt, '0);
    checkCount("rst_bubble_cnt", bubble_cnt, '0);
    rst = 1'b1; dcache_resp = 1'b1;
    checkOutput("fresh_resp", V_ALL);
    control_word_ExMem = '0; dcache_resp = 1'b0;
    applyStimulus(2);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
